// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the memory arbiter slice.
//   word_t      : address/data word of the CPU memory interface
//   ramstate_t  : status reported by the RAM model each cycle
//   arb_state_t : grant state of the instruction/data memory arbiter
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Starvation tracker for the instruction port of mem_arbiter.
// Counts data grants handed out while an instruction request was waiting.
// Implemented as a down-counter of remaining data-grant credits: a reload
// corresponds to a starvation count of 0, and max_hit means the count has
// reached STARVE_MAX (no credits left).
//   CLK     : clock
//   RST     : asynchronous active-high reset (count back to 0)
//   inc     : one more data grant taken while instruction was pending
//   clr     : instruction port granted, forget the history
//   max_hit : starvation count equals STARVE_MAX
module arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic inc,
  input  logic clr,
  output logic max_hit
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] RELOAD = CW'(STARVE_MAX);

  logic [CW-1:0] credit_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      credit_q <= RELOAD;
    end else if (clr) begin
      credit_q <= RELOAD;
    end else if (inc && (credit_q != '0)) begin
      // saturates at zero credits, i.e. count stays at STARVE_MAX
      credit_q <= credit_q - CW'(1);
    end
  end

  assign max_hit = (credit_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single RAM port.
// Data normally has priority; the instruction port is forced through after
// STARVE_MAX consecutive data grants taken while it was waiting.
// Each grant serves exactly one RAM transfer, then returns to IDLE.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | no grant, RAM enables low, arbitration cycle
//   IGNT  | instruction port owns the RAM until ACCESS
//   DGNT  | data port owns the RAM until ACCESS
//
// Ports:
//   CLK, RST               : clock, async active-high reset
//   iREN, iaddr            : instruction read request/address
//   iload, iwait           : instruction read data / stall
//   dREN, dWEN             : data read / write request
//   daddr, dstore          : data address / write data
//   dload, dwait           : data read data / stall
//   ramREN, ramWEN         : RAM read / write enable
//   ramaddr, ramstore      : RAM address / write data
//   ramload, ramstate      : RAM read data / status
//   err                    : sticky, set when the RAM reports ERROR
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              RST,
  // instruction port
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [ADDR_W-1:0] iload,
  output logic              iwait,
  // data port
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [ADDR_W-1:0] dstore,
  output logic [ADDR_W-1:0] dload,
  output logic              dwait,
  // RAM side
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [ADDR_W-1:0] ramstore,
  input  logic [ADDR_W-1:0] ramload,
  input  ramstate_t         ramstate,
  // status
  output logic              err
);

  arb_state_t state_q;
  arb_state_t arb_pick;
  logic       err_q;
  logic       d_req;
  logic       starve_max;
  logic       starve_inc;
  logic       starve_clr;

  assign d_req = dREN | dWEN;

  // Arbitration result used only while in IDLE.
  always_comb begin
    arb_pick = IDLE;
    if (d_req && !(starve_max && iREN)) begin
      arb_pick = DGNT;
    end else if (iREN) begin
      arb_pick = IGNT;
    end
  end

  assign starve_inc = (state_q == IDLE) && (arb_pick == DGNT) && iREN;
  assign starve_clr = (state_q == IDLE) && (arb_pick == IGNT);

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .CLK     (CLK),
    .RST     (RST),
    .inc     (starve_inc),
    .clr     (starve_clr),
    .max_hit (starve_max)
  );

  // A dropped request ends the grant; an ERROR only matters to a live
  // requester, which stays granted and retries.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= arb_pick;
        end
        IGNT: begin
          if (!iREN || (ramstate == ACCESS)) begin
            state_q <= IDLE;
          end
          if (iREN && (ramstate == ERROR)) begin
            err_q <= 1'b1;
          end
        end
        DGNT: begin
          if (!d_req || (ramstate == ACCESS)) begin
            state_q <= IDLE;
          end
          if (d_req && (ramstate == ERROR)) begin
            err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // RAM-side mux; enables follow the live request so an abort takes
  // effect in the same cycle.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_q)
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
      end
      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      default: begin
      end
    endcase
  end

  assign iload = ramload;
  assign dload = ramload;

  assign iwait = iREN  & ~((state_q == IGNT) && (ramstate == ACCESS));
  assign dwait = d_req & ~((state_q == DGNT) && (ramstate == ACCESS));

  assign err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int SMAX = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, err;
  ramstate_t   ramstate = FREE;

  int n_vec  = 0;
  int n_miss = 0;

  // reference model: who owns the RAM (0 none, 1 instruction, 2 data)
  int m_owner  = 0;
  int m_starve = 0;
  bit m_err    = 1'b0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.STARVE_MAX(SMAX), .ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .err(err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = 0;
    m_starve = 0;
    m_err    = 1'b0;
  endtask

  // Apply one cycle of inputs, compare all outputs against the model,
  // then advance the model across the clock edge.
  task automatic step(input logic i_r, input logic d_r, input logic d_w,
                      input logic [31:0] ia, input logic [31:0] da,
                      input logic [31:0] ds, input logic [31:0] rl,
                      input ramstate_t rs);
    logic        e_ren, e_wen, d_any;
    logic [31:0] e_addr, e_store;
    iREN = i_r; dREN = d_r; dWEN = d_w;
    iaddr = ia; daddr = da; dstore = ds; ramload = rl; ramstate = rs;
    #2;
    d_any   = d_r | d_w;
    e_ren   = (m_owner == 1) ? i_r : (m_owner == 2) ? (d_r & ~d_w) : 1'b0;
    e_wen   = (m_owner == 2) ? d_w : 1'b0;
    e_addr  = (m_owner == 1) ? ia : (m_owner == 2) ? da : 32'h0;
    e_store = (m_owner == 2) ? ds : 32'h0;
    check("ramREN",   64'(ramREN),   64'(e_ren));
    check("ramWEN",   64'(ramWEN),   64'(e_wen));
    check("ramaddr",  64'(ramaddr),  64'(e_addr));
    check("ramstore", 64'(ramstore), 64'(e_store));
    check("iwait",    64'(iwait),    64'(i_r & ~(m_owner == 1 && rs == ACCESS)));
    check("dwait",    64'(dwait),    64'(d_any & ~(m_owner == 2 && rs == ACCESS)));
    check("iload",    64'(iload),    64'(rl));
    check("dload",    64'(dload),    64'(rl));
    check("err",      64'(err),      64'(m_err));
    case (m_owner)
      0: begin
        if (d_any && !(m_starve == SMAX && i_r)) begin
          m_owner = 2;
          if (i_r && m_starve < SMAX) m_starve++;
        end else if (i_r) begin
          m_owner  = 1;
          m_starve = 0;
        end
      end
      1: begin
        if (i_r && rs == ERROR) m_err = 1'b1;
        if (!i_r || rs == ACCESS) m_owner = 0;
      end
      default: begin
        if (d_any && rs == ERROR) m_err = 1'b1;
        if (!d_any || rs == ACCESS) m_owner = 0;
      end
    endcase
    @(posedge CLK);
    #1;
  endtask

  int n_dg;
  int n_dg_at_ig;
  bit ig_seen;
  bit ri, rd, rw;
  logic [31:0] ra_i, ra_d, r_st;
  ramstate_t rs_r;
  int pick;

  initial begin
    // reset state, with an instruction request already present
    iREN = 1'b1; dWEN = 1'b1; daddr = 32'h1234; iaddr = 32'h5678;
    #3;
    check("rst_ramREN",   64'(ramREN),   64'h0);
    check("rst_ramWEN",   64'(ramWEN),   64'h0);
    check("rst_ramaddr",  64'(ramaddr),  64'h0);
    check("rst_ramstore", 64'(ramstore), 64'h0);
    check("rst_iwait",    64'(iwait),    64'h1);
    check("rst_dwait",    64'(dwait),    64'h1);
    check("rst_err",      64'(err),      64'h0);
    iREN = 1'b0; dWEN = 1'b0;
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    model_reset();

    // single instruction read
    step(1, 0, 0, 32'h40, 0, 0, 32'h11, BUSY);
    step(1, 0, 0, 32'h40, 0, 0, 32'h22, BUSY);
    check("rd_addr", 64'(ramaddr), 64'h40);
    step(1, 0, 0, 32'h40, 0, 0, 32'hCAFE, ACCESS);
    step(0, 0, 0, 32'h40, 0, 0, 32'h0, FREE);

    // write wins over read on the data port
    step(0, 1, 1, 0, 32'h80, 32'hDEADBEEF, 0, BUSY);
    step(0, 1, 1, 0, 32'h80, 32'hDEADBEEF, 0, BUSY);
    check("wr_store", 64'(ramstore), 64'hDEADBEEF);
    step(0, 1, 1, 0, 32'h80, 32'hDEADBEEF, 0, ACCESS);
    step(0, 0, 0, 0, 0, 0, 0, FREE);

    // starvation: instruction held, data requests back to back
    n_dg = 0; ig_seen = 1'b0; n_dg_at_ig = -1;
    for (int k = 0; k < 14; k++) begin
      step(1, 1, 0, 32'hA0, 32'hB0, 0, 32'(k), ACCESS);
      if (ramREN && ramaddr == 32'hB0 && !ig_seen) n_dg++;
      if (ramREN && ramaddr == 32'hA0 && !ig_seen) begin
        ig_seen = 1'b1;
        n_dg_at_ig = n_dg;
      end
    end
    check("starve_dgnts", 64'(n_dg_at_ig), 64'(SMAX));
    step(0, 0, 0, 0, 0, 0, 0, FREE);

    // error retry on a data read
    step(0, 1, 0, 0, 32'hC0, 0, 0, BUSY);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0, 32'hC0, 0, 0, ERROR);
    end
    check("err_sticky", 64'(err), 64'h1);
    step(0, 1, 0, 0, 32'hC0, 0, 32'h77, ACCESS);
    step(0, 0, 0, 0, 0, 0, 0, FREE);
    check("err_after", 64'(err), 64'h1);

    // dropped instruction request mid-grant
    step(1, 0, 0, 32'hD0, 0, 0, 0, BUSY);
    step(1, 0, 0, 32'hD0, 0, 0, 0, BUSY);
    step(0, 0, 0, 32'hD0, 0, 0, 0, BUSY);
    step(0, 0, 0, 32'hD0, 0, 0, 0, BUSY);

    // reset pulsed while the data port holds a write grant
    step(0, 0, 1, 0, 32'hE0, 32'h55, 0, BUSY);
    #2;
    check("pre_rst_wen", 64'(ramWEN), 64'h1);
    RST = 1'b1;
    #1;
    check("mid_rst_wen", 64'(ramWEN), 64'h0);
    check("mid_rst_ren", 64'(ramREN), 64'h0);
    check("mid_rst_err", 64'(err),    64'h0);
    model_reset();
    @(negedge CLK);
    dWEN = 1'b0;
    RST = 1'b0;
    @(posedge CLK); #1;

    // randomized traffic against the reference model
    ri = 0; rd = 0; rw = 0; ra_i = 0; ra_d = 0; r_st = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(3) == 0) begin ri = $urandom_range(1); ra_i = $urandom; end
      if ($urandom_range(3) == 0) begin
        rd = $urandom_range(1); rw = $urandom_range(1);
        ra_d = $urandom; r_st = $urandom;
      end
      pick = $urandom_range(19);
      rs_r = (pick < 4) ? FREE : (pick < 10) ? BUSY : (pick < 19) ? ACCESS : ERROR;
      step(ri, rd, rw, ra_i, ra_d, r_st, $urandom, rs_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, which is the number of consecutive data grants allowed while an instruction request is pending.
REQ-002 SHALL have parameter ADDR_W, default 32, which is the width of the address and data words (word_t).
REQ-003 SHALL have ports CLK (in, 1), the single clock, and RST (in, 1), the reset; reset is asynchronous and active-high.
REQ-004 SHALL have the following instruction-port signals:
- iREN (in, 1): instruction read request.
- iaddr (in, 32): instruction address.
- iload (out, 32): instruction read data.
- iwait (out, 1): instruction port stall.
REQ-005 SHALL have the following data-port signals:
- dREN (in, 1): data read request.
- dWEN (in, 1): data write request.
- daddr (in, 32): data address.
- dstore (in, 32): data write data.
- dload (out, 32): data read data.
- dwait (out, 1): data port stall.
REQ-006 SHALL have the following RAM-side signals:
- ramREN (out, 1): RAM read enable.
- ramWEN (out, 1): RAM write enable.
- ramaddr (out, 32): RAM address.
- ramstore (out, 32): RAM write data.
- ramload (in, 32): RAM read data.
- ramstate (in, ramstate_t): RAM status, one of FREE, BUSY, ACCESS, ERROR.
REQ-007 SHALL have port err (out, 1), a sticky flag set on a RAM error.

Function
REQ-008 SHALL implement a registered FSM with three states: IDLE (no grant), IGNT (instruction port granted) and DGNT (data port granted).
REQ-009 SHALL arbitrate in IDLE: the next state is DGNT if dREN|dWEN is asserted, else IGNT if iREN is asserted, else IDLE. This gives one cycle of arbitration latency.
REQ-010 SHALL override data priority with starvation: if starve_cnt==STARVE_MAX and iREN is asserted in IDLE, the next state is IGNT even when a data request is pending.
REQ-011 SHALL increment starve_cnt, saturating at STARVE_MAX, on each IDLE->DGNT transition taken while iREN is asserted.
REQ-012 SHALL clear starve_cnt to 0 on every IDLE->IGNT transition.
REQ-013 SHALL, in IGNT, drive ramREN=iREN, ramWEN=0, ramaddr=iaddr and ramstore=0.
REQ-014 SHALL, in DGNT, drive ramWEN=dWEN, ramREN=dREN&~dWEN (a write wins when both are asserted), ramaddr=daddr and ramstore=dstore.
REQ-015 SHALL, in IDLE, drive all RAM enables, ramaddr and ramstore to 0.
REQ-016 SHALL pass ramload combinationally to iload and to dload at all times.
REQ-017 SHALL drive the wait signals as follows:
- iwait=iREN & ~(state==IGNT & ramstate==ACCESS).
- dwait=(dREN|dWEN) & ~(state==DGNT & ramstate==ACCESS).
REQ-018 SHALL return from IGNT or DGNT to IDLE on the cycle after ramstate==ACCESS, so each grant serves exactly one transfer.
REQ-019 SHALL remain in the granted state on ramstate==ERROR, keep the wait signal high, retry the transfer and set err=1.
REQ-020 SHALL abort a grant whose requester drops its request mid-grant: the next state is IDLE and the RAM enables deassert combinationally in the same cycle.
REQ-021 SHALL accept simultaneous iREN and data requests in IDLE and resolve them per REQ-009 and REQ-010; the loser holds its wait high until it is served.
REQ-022 SHALL keep all RAM enables at 0 whenever state==IDLE; a back-to-back request from the same port therefore always passes through one IDLE cycle.

Reset
REQ-023 SHALL apply the following values asynchronously on RST=1: state=IDLE, starve_cnt=0 and err=0.
REQ-024 SHALL, while RST=1, drive ramREN=0, ramWEN=0, ramaddr=0 and ramstore=0; iwait and dwait follow REQ-017 with state=IDLE.
REQ-025 SHALL abandon any in-flight transfer when reset is asserted mid-grant and issue no RAM enable until a new IDLE arbitration occurs.

Structure
REQ-026 SHALL import word_t and ramstate_t from cpu_types_pkg.
REQ-027 SHALL add arb_state_t {IDLE, IGNT, DGNT} to cpu_types_pkg.
REQ-028 SHALL place the starvation counter in one sub-module, arb_starve_cnt, with ports inc, clr and max_hit, parameterised by STARVE_MAX.
REQ-029 SHALL keep the FSM and the output muxing in mem_arbiter.

Verification
REQ-030 SHALL cover a single read: iREN=1, iaddr=0x40 and ramstate goes BUSY then ACCESS after 2 cycles -> ramREN=1 and ramaddr=0x40 from cycle 1; iwait=0 in the ACCESS cycle; state=IDLE on the next cycle.
REQ-031 SHALL cover a write winning over a read: dREN=1, dWEN=1, daddr=0x80, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait=0 on ACCESS.
REQ-032 SHALL cover starvation: iREN held high with 5 back-to-back data requests and STARVE_MAX=4 -> the 5th arbitration grants IGNT; starve_cnt=0 afterwards.
REQ-033 SHALL cover an error retry: grant DGNT, then ramstate=ERROR for 3 cycles followed by ACCESS -> dwait=1 throughout the error, err=1 sticky, and a single completion.
REQ-034 SHALL cover a dropped request: iREN deasserted in IGNT before ACCESS -> ramREN=0 in the same cycle and state=IDLE on the next cycle.
REQ-035 SHALL cover reset mid-grant: RST pulsed in DGNT -> ramWEN=0 and ramREN=0 immediately; state=IDLE, err=0 and starve_cnt=0.
